// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
//
// Purpose:
//   Shared pipeline definitions for the pipeline register slice: the control
//   state encoding, the MODE selector constants and a helper that maps a
//   control state onto the number of entries it represents.
//
// Contents:
//   state_e          EMPTY / BUSY / FULL control states
//   MODE_PASS        single-entry pass register
//   MODE_SKID        two-entry skid register
//   OCC_W            width of the occupancy count
//   state_occupancy  state -> number of held entries
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

  // The encoding is chosen so that bit 0 means "main register valid" and
  // bit 1 means "skid register valid".
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  localparam int MODE_PASS = 0;
  localparam int MODE_SKID = 1;

  localparam int OCC_W = 2;

  // Number of entries held in a given control state.
  function automatic logic [OCC_W-1:0] state_occupancy(input state_e s);
    logic [OCC_W-1:0] occ;
    occ = 2'd0;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_BUSY:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg_data.sv
// -----------------------------------------------------------------------------
// pipe_data_reg
//
// Purpose:
//   One payload register of the pipeline slice. Loads d when en is high and
//   returns to RESET_VAL on a synchronous active-low reset. Used once for the
//   main (head) entry and, in skid mode, once more for the skid entry.
//
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      synchronous reset, active low
//   en   in   1      load enable
//   d    in   WIDTH  value to load
//   q    out  WIDTH  register contents
// -----------------------------------------------------------------------------
module pipe_data_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : pipe_data_reg

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Purpose:
//   Valid/ready pipeline register slice. MODE_SKID builds a two-entry skid
//   register whose in_ready is a flop, so out_ready never reaches in_ready
//   combinationally. MODE_PASS builds a single-entry register whose in_ready
//   is derived combinationally from out_ready. A flush empties the slice on
//   the next edge (pipeline kill); reset has priority over everything.
//
// Parameters:
//   WIDTH      payload width in bits (1..128)
//   RESET_VAL  value loaded into every data register on reset
//   MODE       MODE_PASS (0) or MODE_SKID (1)
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   rst        in   1      synchronous reset, active low
//   flush      in   1      discard all held entries
//   in_valid   in   1      upstream presents in_data
//   in_ready   out  1      slice can accept this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data holds a valid entry
//   out_ready  in   1      downstream accepts this cycle
//   out_data   out  WIDTH  head-entry payload, straight from the main register
//   occupancy  out  2      number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               MODE      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  // Any MODE other than the pass value builds the skid variant.
  localparam bit IS_SKID = (MODE != MODE_PASS);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e           r_state;
  state_e           w_state_next;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;

  logic             w_main_en;
  logic             w_main_from_skid;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // The main register is valid in BUSY and FULL, i.e. whenever state is not
  // EMPTY; out_valid therefore comes straight from the state flops.
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Control state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and data-register enables
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_main_en        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_en        = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_next = ST_BUSY;
          w_main_en    = 1'b1;
        end
      end

      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          // Head leaves while the new entry takes its place.
          w_state_next = ST_BUSY;
          w_main_en    = 1'b1;
        end else if (w_in_fire) begin
          // Only reachable in skid mode: in pass mode an accepted input while
          // BUSY implies out_ready, hence an output transfer as well.
          if (IS_SKID) begin
            w_state_next = ST_FULL;
            w_skid_en    = 1'b1;
          end
        end else if (w_out_fire) begin
          w_state_next = ST_EMPTY;
        end
      end

      ST_FULL: begin
        // in_ready is low here, so only the output side can move.
        if (w_out_fire) begin
          w_state_next     = ST_BUSY;
          w_main_en        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase

    // Flush kills every transfer of this cycle. The data registers are left
    // untouched: their contents are don't-care once out_valid drops.
    if (flush) begin
      w_state_next     = ST_EMPTY;
      w_main_en        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_en        = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Main (head) data register
  // ---------------------------------------------------------------------------
  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (w_main_en),
    .d   (w_main_d),
    .q   (w_main_q)
  );

  // ---------------------------------------------------------------------------
  // Mode-dependent ready path and skid storage
  // ---------------------------------------------------------------------------
  generate
    if (IS_SKID) begin : g_skid
      logic r_in_ready;

      // Registered ready: high whenever the state about to be entered still
      // has a free slot. Looking at the next state keeps it exactly equal to
      // (state != FULL) without any path from out_ready to in_ready.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_next != ST_FULL);
        end
      end

      assign w_in_ready = r_in_ready;

      pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (w_skid_en),
        .d   (in_data),
        .q   (w_skid_q)
      );
    end else begin : g_pass
      // Single entry: accept when empty or when the head leaves this cycle.
      assign w_in_ready = out_ready | ~w_out_valid;
      assign w_skid_q   = RESET_VAL;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_main_q;
  assign occupancy = state_occupancy(r_state);

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Drives one skid-mode and one pass-mode instance with the same stimulus and
// compares both against queue-based reference models every cycle, around a
// set of directed scenarios followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int               W     = 32;
  localparam logic [W-1:0]     RV1   = 32'hDEAD_BEEF;
  localparam logic [W-1:0]     RV0   = 32'h0000_5A5A;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [1:0]   occ1;
  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   occ0;

  int checks = 0;
  int errors = 0;

  // Reference state: FIFO contents in acceptance order.
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  bit           fresh1;
  bit           fresh0;
  int           max_occ0 = 0;

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV1), .MODE(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .occupancy (occ1)
  );

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV0), .MODE(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .occupancy (occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare both instances against their models (inputs already settled).
  task automatic check_outputs();
    logic [W-1:0] e;
    e = (q1.size() != 2) ? 1 : 0;
    check("m1_in_ready", {31'd0, in_ready1}, e);
    check("m1_out_valid", {31'd0, out_valid1}, (q1.size() > 0) ? 1 : 0);
    check("m1_occupancy", {30'd0, occ1}, q1.size());
    if (q1.size() > 0) check("m1_out_data", out_data1, q1[0]);
    else if (fresh1)   check("m1_reset_data", out_data1, RV1);

    e = (out_ready || q0.size() == 0) ? 1 : 0;
    check("m0_in_ready", {31'd0, in_ready0}, e);
    check("m0_out_valid", {31'd0, out_valid0}, (q0.size() > 0) ? 1 : 0);
    check("m0_occupancy", {30'd0, occ0}, q0.size());
    if (q0.size() > 0) check("m0_out_data", out_data0, q0[0]);
    else if (fresh0)   check("m0_reset_data", out_data0, RV0);
    if (int'(occ0) > max_occ0) max_occ0 = int'(occ0);
  endtask

  // Apply the rules of one clock edge to the models.
  task automatic model_update();
    bit rdy1, rdy0;
    rdy1 = (q1.size() != 2);
    rdy0 = out_ready || (q0.size() == 0);
    if (!rst) begin
      q1.delete(); q0.delete();
      fresh1 = 1'b1; fresh0 = 1'b1;
    end else if (flush) begin
      q1.delete(); q0.delete();
      fresh1 = 1'b0; fresh0 = 1'b0;
    end else begin
      if (q1.size() > 0 && out_ready) begin
        $display("tx skid out 0x%08h", q1[0]);
        void'(q1.pop_front());
      end
      if (in_valid && rdy1) begin
        q1.push_back(in_data);
        fresh1 = 1'b0;
      end
      if (q0.size() > 0 && out_ready) begin
        $display("tx pass out 0x%08h", q0[0]);
        void'(q0.pop_front());
      end
      if (in_valid && rdy0) begin
        q0.push_back(in_data);
        fresh0 = 1'b0;
      end
    end
  endtask

  // One clock: check before the edge, update models at the edge, settle.
  task automatic cycle(input bit chk);
    #1;
    if (chk) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset held for two cycles.
    cycle(0);
    cycle(0);
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid1}, 0);
    check("rst_occupancy", {30'd0, occ1}, 0);
    check("rst_in_ready", {31'd0, in_ready1}, 1);
    check("rst_out_data", out_data1, RV1);
    check("rst_pass_in_ready", {31'd0, in_ready0}, 1);
    check("rst_pass_out_data", out_data0, RV0);
    cycle(1);

    // Streaming 0x1..0x10 with downstream always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = i;
      check("stream_in_ready", {31'd0, in_ready1}, 1);
      cycle(1);
      check("stream_out_data", out_data1, i);
    end
    in_valid = 1'b0;
    cycle(1);
    cycle(1);

    // Backpressure: 0xA and 0xB pile up, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA; cycle(1);
    in_data   = 32'hB; cycle(1);
    in_valid  = 1'b0;
    check("bp_occupancy", {30'd0, occ1}, 2);
    check("bp_in_ready", {31'd0, in_ready1}, 0);
    check("bp_head", out_data1, 32'hA);
    cycle(1);
    check("bp_hold", out_data1, 32'hA);
    out_ready = 1'b1;
    cycle(1);
    check("bp_second", out_data1, 32'hB);
    cycle(1);
    check("bp_drained", {30'd0, occ1}, 0);

    // Flush while FULL, with 0xC offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11; cycle(1);
    in_data   = 32'h12; cycle(1);
    check("fl_full", {30'd0, occ1}, 2);
    flush = 1'b1; in_data = 32'hC; out_ready = 1'b1;
    cycle(1);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_occupancy", {30'd0, occ1}, 0);
    check("fl_out_valid", {31'd0, out_valid1}, 0);
    check("fl_pass_out_valid", {31'd0, out_valid0}, 0);
    for (int i = 0; i < 3; i++) cycle(1);

    // Reset while FULL, overriding flush and an offered input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h21; cycle(1);
    in_data   = 32'h22; cycle(1);
    rst = 1'b0; flush = 1'b1; in_data = 32'h23;
    cycle(1);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    check("rm_occupancy", {30'd0, occ1}, 0);
    check("rm_out_data", out_data1, RV1);
    check("rm_in_ready", {31'd0, in_ready1}, 1);
    check("rm_pass_out_data", out_data0, RV0);
    cycle(1);

    // Pass mode holding 0x5 under backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5; cycle(1);
    in_data   = 32'h6;
    #1;
    check("m0_hold_in_ready", {31'd0, in_ready0}, 0);
    cycle(1);
    check("m0_hold_data", out_data0, 32'h5);
    check("m0_hold_occ", {30'd0, occ0}, 1);
    out_ready = 1'b1;
    #1;
    check("m0_comb_ready", {31'd0, in_ready0}, 1);
    in_valid = 1'b0;
    cycle(1);
    cycle(1);
    cycle(1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 63) != 0);
      cycle(1);
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle(1);
    cycle(1);
    cycle(1);

    check("m0_occ_max", (max_occ0 <= 1) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, payload width in bits (1..128).
REQ-002 SHALL provide parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data register on reset.
REQ-003 SHALL provide parameter MODE, default 1, where 0 = single-entry pass register and 1 = two-entry skid register.
REQ-004 SHALL provide clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL provide rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL provide flush  input  1  discards all held entries, for pipeline kill on branch or exception.
REQ-007 SHALL provide in_valid  input  1  upstream presents in_data.
REQ-008 SHALL provide in_ready  output  1  block can accept; a transfer occurs when in_valid & in_ready.
REQ-009 SHALL provide in_data  input  WIDTH  upstream payload.
REQ-010 SHALL provide out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL provide out_ready  input  1  downstream can accept; a transfer occurs when out_valid & out_ready.
REQ-012 SHALL provide out_data  output  WIDTH  head-entry payload, driven directly from a register.
REQ-013 SHALL provide occupancy  output  2  number of held entries (0..2; never exceeds 1 in MODE 0).

Function
REQ-014 SHALL use states EMPTY (0 entries), BUSY (main register valid) and FULL (main and skid registers valid); FULL is unreachable in MODE 0.
REQ-015 In MODE 1, in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready.
REQ-016 In MODE 0, in_ready SHALL equal out_ready | ~out_valid (combinational).
REQ-017 EMPTY: on an input transfer the block SHALL move to BUSY with main <= in_data, giving one-cycle latency to out_valid.
REQ-018 BUSY, input and output transfer in the same cycle: the block SHALL stay BUSY with main <= in_data.
REQ-019 BUSY, input transfer only: the block SHALL move to FULL with skid <= in_data and main unchanged (MODE 1 only).
REQ-020 BUSY, output transfer only: the block SHALL move to EMPTY.
REQ-021 FULL, output transfer: the block SHALL move to BUSY with main <= skid.
REQ-022 FULL, no output transfer: the block SHALL hold state and both registers.
REQ-023 Order SHALL be preserved: entries leave in the order they were accepted, with none lost or duplicated.
REQ-024 out_data and main SHALL NOT change while out_valid=1 and out_ready=0.
REQ-025 flush=1 SHALL force EMPTY on the next edge, overriding all transfers that cycle; any input transfer in that cycle is dropped.
REQ-026 The data registers SHALL NOT be cleared by flush; out_data after a flush is don't-care while out_valid=0.
REQ-027 occupancy SHALL read 0, 1 and 2 for EMPTY, BUSY and FULL respectively.
REQ-028 in_valid asserted while in_ready=0 SHALL have no effect.

Reset
REQ-029 When rst=0 at a clock edge, the block SHALL enter EMPTY with out_valid=0, occupancy=0, and main=skid=RESET_VAL.
REQ-030 After reset, in_ready SHALL be 1 (MODE 1 registered value; MODE 0 by REQ-016).
REQ-031 Reset SHALL take priority over flush and over all transfers, including mid-operation from FULL.
REQ-032 No output SHALL be X after the first reset edge.

Structure
REQ-033 The state encoding (EMPTY=2'b00, BUSY=2'b01, FULL=2'b11) and the MODE constants SHALL reside in the shared pipeline package.
REQ-034 The block SHALL instantiate a sub-module pipe_data_reg (WIDTH, RESET_VAL; clk, rst, en, d, q) twice, once each for main and skid.
REQ-035 In MODE 0, the skid instance SHALL be removed by generate.

Verification
REQ-036 Reset: hold rst=0 for 2 cycles, then release -> out_valid=0, occupancy=0, in_ready=1, out_data=RESET_VAL.
REQ-037 Streaming in MODE 1: out_ready=1, in_data 0x1..0x10 on consecutive cycles -> out_data 0x1..0x10 one cycle later, in_ready never 0.
REQ-038 Backpressure: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0 and out_data=0xA held; then out_ready=1 -> outputs 0xA then 0xB, no loss.
REQ-039 Flush in FULL: assert flush together with in_valid (0xC) -> next cycle out_valid=0, occupancy=0, and 0xC never appears.
REQ-040 Reset mid-operation: rst=0 while FULL -> next cycle EMPTY, out_data=RESET_VAL.
REQ-041 MODE 0: out_ready=0 while holding 0x5 -> in_ready=0 combinationally; occupancy never reaches 2.
